c2_serial_unit: RTL and testbench
=================================

# c2_serial_unit

Parametrised, bit-serial two's-complement unit: converts a WIDTH-bit operand one bit per clock, LSB first, using the copy-up-to-first-one-then-invert rule. Supports four modes: pass, negate, absolute value, and sign-magnitude to two's complement. It replaces the fixed 4-bit combinational complementer wherever operand width is configurable and area matters more than latency. It has a start/busy/done handshake for use under a sequencing controller.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request. Sampled only when idle; captures din and mode.
- mode  in  2  00 pass, 01 negate, 10 absolute value, 11 sign-magnitude to two's complement.
- din  in  WIDTH  operand. Two's complement for modes 01/10; sign-magnitude for mode 11.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when dout/ovf are updated.
- dout  out  WIDTH  result. Held until the next completion.
- ovf  out  1  result not representable. Held with dout.

## Operation
- States: IDLE, SHIFT.
- IDLE:
  - start=1 loads the shift register and a bit counter (cnt=0), then enters SHIFT.
  - For mode 11, the loaded operand has bit WIDTH-1 cleared (magnitude only).
  - The invert flag neg is latched at load:
    - mode 01: neg=1.
    - mode 10 or 11: neg=din[WIDTH-1].
    - mode 00: neg=0.
- SHIFT: each cycle processes bit b = sr[0]:
  - Output bit = neg & seen ? ~b : b.
  - seen |= b, where seen is cleared at load.
  - The output bit shifts into the result register from the MSB side.
  - cnt increments.
  - When cnt reaches WIDTH-1, the last bit is processed. The result register is copied to dout, done pulses, and the state returns to IDLE.
- ovf:
  - Set when mode is 01 or 10 and din = 1 followed by WIDTH-1 zeros (most negative value). dout then equals din.
  - Always 0 for modes 00 and 11.
  - Computed at load and presented with dout.
- Mode 11 negative zero (1 followed by zeros) yields dout=0, ovf=0.
- start while busy=1 is ignored; din/mode changes during SHIFT have no effect.
- Negating 0 yields 0 with ovf=0.

## Timing
- Reset values: busy=0, done=0, dout=0, ovf=0, state IDLE, internal registers 0.
- Reset acts immediately at any time, including mid-conversion. The in-flight operation is discarded and no done is produced.
- Start accepted at edge E0: busy=1 after E0.
- Bits are processed at edges E1..EWIDTH.
- After edge EWIDTH: done=1 for exactly one cycle, busy=0, dout/ovf valid.
- Latency is WIDTH cycles from the accepting edge to done, independent of mode and data.
- Back-to-back: start asserted during the done cycle is accepted (state is IDLE). Throughput is one result per WIDTH cycles.
- busy and done are never high in the same cycle.
- dout/ovf change only on the done edge or on reset.

## Test plan
- WIDTH=8, mode 01, din 0x05 -> after 8 cycles: done pulse, dout 0xFB, ovf 0. Repeat with din 0x00 -> dout 0x00, ovf 0.
- Mode 01, din 0x80 -> dout 0x80, ovf 1. Mode 10, din 0x80 -> dout 0x80, ovf 1.
- Mode 10, din 0xF0 -> dout 0x10; din 0x23 -> dout 0x23. Mode 00, din 0xA7 -> dout 0xA7. All ovf 0.
- Mode 11: din 0x85 -> dout 0xFB; din 0x05 -> dout 0x05; din 0x80 -> dout 0x00. All ovf 0.
- Handshake:
  - start pulsed again at cycle 3 of a conversion with a different din -> ignored; first result unchanged.
  - start held during the done cycle -> second conversion completes exactly 8 cycles later.
- rst asserted at cycle 4 of a conversion -> busy, done, dout, ovf go to 0 without waiting for a clock edge; no done follows.
- Repeat all of the above with WIDTH=4 (mode 01: 0x3 -> 0xD; 0x8 -> 0x8, ovf 1) and WIDTH=16 (mode 01: 0x0001 -> 0xFFFF).

Source files
------------

// File: rtl/c2_serial_unit.sv
// ----------------------------------------------------------------------------
// c2_serial_unit
//
// Bit-serial two's-complement unit. A WIDTH-bit operand is captured on start
// and processed one bit per clock, LSB first, with the copy-up-to-first-one-
// then-invert rule: bits are copied until (and including) the first 1, and
// every later bit is inverted when the operation needs a negation.
//
// Modes:
//   00  pass                         dout = din
//   01  negate                       dout = -din
//   10  absolute value               dout = |din|
//   11  sign-magnitude -> two's comp dout = sign ? -mag : mag
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous active-high reset
//   start  in   1      request, sampled only while idle; captures din and mode
//   mode   in   2      operation select (see above)
//   din    in   WIDTH  operand
//   busy   out  1      conversion in progress
//   done   out  1      one-cycle pulse when dout/ovf are updated
//   dout   out  WIDTH  result, held until the next completion
//   ovf    out  1      result not representable, held with dout
//
// Latency is WIDTH cycles from the accepting edge to the done pulse,
// regardless of mode or data. A start seen during the done cycle is accepted.
// ----------------------------------------------------------------------------
module c2_serial_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_NEG  = 2'b01;
  localparam logic [1:0] MODE_ABS  = 2'b10;
  localparam logic [1:0] MODE_SM   = 2'b11;

  localparam logic IDLE  = 1'b0;
  localparam logic SHIFT = 1'b1;

  // Most negative two's-complement value: the one operand whose negation
  // does not fit in WIDTH bits.
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);

  logic             state;
  logic [WIDTH-1:0] sr;        // operand being consumed, LSB first
  logic [WIDTH-1:0] res;       // result being assembled from the MSB side
  logic [CW-1:0]    cnt;       // index of the bit processed this cycle
  logic             neg;       // invert bits after the first 1
  logic             seen;      // a 1 has already been copied
  logic             ovf_pend;  // overflow decided at load, published at done

  logic             load_neg;
  logic             load_ovf;
  logic [WIDTH-1:0] load_sr;
  logic             out_bit;
  logic [WIDTH-1:0] res_next;
  logic             last_bit;

  // Load-time decisions: invert flag, overflow and the operand actually fed
  // to the serial datapath (sign bit stripped for sign-magnitude input).
  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch can be inferred.
  always_comb begin
    load_neg = 1'b0;
    load_ovf = 1'b0;
    load_sr  = din;
    case (mode)
      MODE_PASS: load_neg = 1'b0;
      MODE_NEG: begin
        load_neg = 1'b1;
        load_ovf = (din == MIN_VAL);
      end
      MODE_ABS: begin
        load_neg = din[WIDTH-1];
        load_ovf = (din == MIN_VAL);
      end
      MODE_SM: begin
        load_neg = din[WIDTH-1];
        load_sr  = {1'b0, din[WIDTH-2:0]};
      end
      default: load_neg = 1'b0;
    endcase
  end

  // Serial datapath: the current bit is inverted only once a 1 has already
  // gone by, which is exactly what two's-complement negation does.
  always_comb begin
    out_bit  = (neg && seen) ? ~sr[0] : sr[0];
    res_next = {out_bit, res[WIDTH-1:1]};
    last_bit = (cnt == LAST_CNT);
  end

  assign busy = (state == SHIFT);

  // NOTE: all state, including the datapath registers, is cleared by reset so
  // that a conversion aborted mid-flight leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sr       <= '0;
      res      <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
      seen     <= 1'b0;
      ovf_pend <= 1'b0;
      dout     <= '0;
      ovf      <= 1'b0;
      done     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // sees the pre-edge value of every other one regardless of order.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sr       <= load_sr;
            res      <= '0;
            cnt      <= '0;
            seen     <= 1'b0;
            neg      <= load_neg;
            ovf_pend <= load_ovf;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          sr   <= sr >> 1;
          res  <= res_next;
          seen <= seen | sr[0];
          cnt  <= cnt + 1'b1;
          if (last_bit) begin
            // The final bit goes straight from res_next into dout, so the
            // result is published on the same edge that processes it.
            dout  <= res_next;
            ovf   <= ovf_pend;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_c2_serial_unit.sv
// ----------------------------------------------------------------------------
// tb_c2_serial_unit
//
// Drives three instances (WIDTH = 4, 8, 16) sharing clock, reset, mode and
// operand bus, each with its own start. Fixed vectors come from a table,
// handshake corner cases are hand-written sequences, and random operations
// are compared against an arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_c2_serial_unit;

  logic        clk;
  logic        rst;
  logic [1:0]  mode;
  logic [31:0] din;

  logic        start4, busy4, done4, ovf4;
  logic [3:0]  dout4;
  logic        start8, busy8, done8, ovf8;
  logic [7:0]  dout8;
  logic        start16, busy16, done16, ovf16;
  logic [15:0] dout16;

  int n_checks = 0;
  int n_errors = 0;

  c2_serial_unit #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .start(start4), .mode(mode), .din(din[3:0]),
    .busy(busy4), .done(done4), .dout(dout4), .ovf(ovf4)
  );

  c2_serial_unit #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode), .din(din[7:0]),
    .busy(busy8), .done(done8), .dout(dout8), .ovf(ovf8)
  );

  c2_serial_unit #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .start(start16), .mode(mode), .din(din[15:0]),
    .busy(busy16), .done(done16), .dout(dout16), .ovf(ovf16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          w;
    logic [1:0]  mode;
    logic [31:0] din;
    logic [31:0] exp_dout;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic get_busy(int w);
    case (w)
      4:       return busy4;
      8:       return busy8;
      default: return busy16;
    endcase
  endfunction

  function automatic logic get_done(int w);
    case (w)
      4:       return done4;
      8:       return done8;
      default: return done16;
    endcase
  endfunction

  function automatic logic get_ovf(int w);
    case (w)
      4:       return ovf4;
      8:       return ovf8;
      default: return ovf16;
    endcase
  endfunction

  function automatic logic [31:0] get_dout(int w);
    case (w)
      4:       return {28'b0, dout4};
      8:       return {24'b0, dout8};
      default: return {16'b0, dout16};
    endcase
  endfunction

  task automatic set_start(input int w, input logic v);
    case (w)
      4:       start4  = v;
      8:       start8  = v;
      default: start16 = v;
    endcase
  endtask

  // Reference model: plain modular arithmetic on the operand's value.
  function automatic logic [32:0] ref_model(int w, logic [1:0] m,
                                            logic [31:0] d);
    longint unsigned mask = (64'd1 << w) - 1;
    longint unsigned minv = 64'd1 << (w - 1);
    longint unsigned x    = longint'(d) & mask;
    longint unsigned mag  = x & (mask >> 1);
    longint unsigned r;
    logic            o    = 1'b0;
    logic            sgn  = (x & minv) != 0;
    case (m)
      2'b00: r = x;
      2'b01: begin r = (mask + 1 - x) & mask; o = (x == minv); end
      2'b10: begin r = sgn ? ((mask + 1 - x) & mask) : x; o = (x == minv); end
      default: r = sgn ? ((mask + 1 - mag) & mask) : mag;
    endcase
    return {o, r[31:0]};
  endfunction

  // Waits for done with a bounded budget; lat counts edges since the
  // accepting edge and is returned so the caller can check latency.
  task automatic wait_done(input int w, input string tag, inout int lat);
    bit got = 0;
    while (!got && lat < w + 4) begin
      @(posedge clk);
      #1;
      lat++;
      if (get_busy(w) && get_done(w))
        check({tag, " busy_and_done"}, 32'd1, 32'd0);
      if (get_done(w)) got = 1;
    end
    if (!got) check({tag, " done_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_op(input int w, input logic [1:0] m, input logic [31:0] d,
                        input string tag, output logic [31:0] got_dout,
                        output logic got_ovf);
    int lat = 0;
    @(negedge clk);
    mode = m;
    din  = d;
    set_start(w, 1'b1);
    @(posedge clk);
    #1;
    check({tag, " busy_after_start"}, 32'(get_busy(w)), 32'd1);
    @(negedge clk);
    set_start(w, 1'b0);
    din = $urandom;  // changes during SHIFT must not matter
    wait_done(w, tag, lat);
    check({tag, " latency"}, 32'(lat), 32'(w));
    check({tag, " busy_at_done"}, 32'(get_busy(w)), 32'd0);
    got_dout = get_dout(w);
    got_ovf  = get_ovf(w);
  endtask

  initial begin
    logic [31:0] gd;
    logic        go;
    logic [32:0] exp;
    int          lat;
    int          w;
    bit          stray;

    vecs[0]  = '{8,  2'b01, 32'h05,   32'hFB,   1'b0};
    vecs[1]  = '{8,  2'b01, 32'h00,   32'h00,   1'b0};
    vecs[2]  = '{8,  2'b01, 32'h80,   32'h80,   1'b1};
    vecs[3]  = '{8,  2'b10, 32'h80,   32'h80,   1'b1};
    vecs[4]  = '{8,  2'b10, 32'hF0,   32'h10,   1'b0};
    vecs[5]  = '{8,  2'b10, 32'h23,   32'h23,   1'b0};
    vecs[6]  = '{8,  2'b00, 32'hA7,   32'hA7,   1'b0};
    vecs[7]  = '{8,  2'b11, 32'h85,   32'hFB,   1'b0};
    vecs[8]  = '{8,  2'b11, 32'h05,   32'h05,   1'b0};
    vecs[9]  = '{8,  2'b11, 32'h80,   32'h00,   1'b0};
    vecs[10] = '{4,  2'b01, 32'h3,    32'hD,    1'b0};
    vecs[11] = '{4,  2'b01, 32'h8,    32'h8,    1'b1};
    vecs[12] = '{4,  2'b11, 32'hD,    32'hB,    1'b0};
    vecs[13] = '{16, 2'b01, 32'h0001, 32'hFFFF, 1'b0};
    vecs[14] = '{16, 2'b10, 32'h8000, 32'h8000, 1'b1};
    vecs[15] = '{16, 2'b00, 32'h1234, 32'h1234, 1'b0};

    rst = 1'b0; mode = 2'b00; din = '0;
    start4 = 1'b0; start8 = 1'b0; start16 = 1'b0;
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      w = (i == 0) ? 4 : (i == 1) ? 8 : 16;
      check($sformatf("reset_busy_w%0d", w), 32'(get_busy(w)), 32'd0);
      check($sformatf("reset_done_w%0d", w), 32'(get_done(w)), 32'd0);
      check($sformatf("reset_dout_w%0d", w), get_dout(w), 32'd0);
      check($sformatf("reset_ovf_w%0d", w),  32'(get_ovf(w)), 32'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < 16; i++) begin
      string tag = $sformatf("vec%0d_w%0d_m%0d_%0h", i, vecs[i].w,
                             vecs[i].mode, vecs[i].din);
      run_op(vecs[i].w, vecs[i].mode, vecs[i].din, tag, gd, go);
      check({tag, " dout"}, gd, vecs[i].exp_dout);
      check({tag, " ovf"}, 32'(go), 32'(vecs[i].exp_ovf));
      @(posedge clk);
      #1;
      check({tag, " done_one_cycle"}, 32'(get_done(vecs[i].w)), 32'd0);
      check({tag, " dout_held"}, get_dout(vecs[i].w), vecs[i].exp_dout);
    end

    // start pulsed again at cycle 3 with different operand: ignored.
    @(negedge clk);
    mode = 2'b01; din = 32'h05; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mode = 2'b00; din = 32'h33; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    lat = 3;
    wait_done(8, "restart_ignored", lat);
    check("restart_ignored latency", 32'(lat), 32'd8);
    check("restart_ignored dout", get_dout(8), 32'hFB);
    stray = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done8 || busy8) stray = 1;
    end
    check("restart_ignored no_second_op", 32'(stray), 32'd0);

    // start held through the done cycle: second op accepted there.
    @(negedge clk);
    mode = 2'b01; din = 32'h05; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mode = 2'b10; din = 32'hF0;
    lat = 0;
    wait_done(8, "b2b_first", lat);
    check("b2b_first latency", 32'(lat), 32'd8);
    check("b2b_first dout", get_dout(8), 32'hFB);
    @(posedge clk);
    #1;
    check("b2b_second accepted", 32'(busy8), 32'd1);
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    wait_done(8, "b2b_second", lat);
    check("b2b_second latency", 32'(lat), 32'd8);
    check("b2b_second dout", get_dout(8), 32'h10);
    check("b2b_second ovf", 32'(ovf8), 32'd0);

    // Reset mid-conversion: immediate clear, no done afterwards.
    run_op(8, 2'b01, 32'h80, "pre_reset", gd, go);
    check("pre_reset ovf", 32'(go), 32'd1);
    @(negedge clk);
    mode = 2'b01; din = 32'h05; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midreset busy", 32'(busy8), 32'd0);
    check("midreset done", 32'(done8), 32'd0);
    check("midreset dout", get_dout(8), 32'd0);
    check("midreset ovf", 32'(ovf8), 32'd0);
    #1 rst = 1'b0;
    stray = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done8 || busy8) stray = 1;
    end
    check("midreset no_done", 32'(stray), 32'd0);

    // Random operations against the reference model.
    for (int i = 0; i < 60; i++) begin
      int sel = $urandom_range(2, 0);
      logic [1:0]  m = 2'($urandom);
      logic [31:0] d = $urandom;
      w = (sel == 0) ? 4 : (sel == 1) ? 8 : 16;
      d = d & ((32'd1 << w) - 1);
      if ($urandom_range(7, 0) == 0) d = 32'd1 << (w - 1);
      exp = ref_model(w, m, d);
      run_op(w, m, d, $sformatf("rnd%0d_w%0d_m%0d_%0h", i, w, m, d), gd, go);
      check($sformatf("rnd%0d dout", i), gd, exp[31:0]);
      check($sformatf("rnd%0d ovf", i), 32'(go), 32'(exp[32]));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
